bcd_seg_scanner: RTL
====================

Name: bcd_seg_scanner

Overview:
- Downstream consumer of the binary-to-BCD converter. Takes the converter's 12-bit BCD word (hundreds, tens, units) and drives a 3-digit common-anode seven-segment display.
- Digits are time-multiplexed, with leading-zero blanking and a tear-free shadow/display register pair.
- A new value is applied only at a frame boundary, so a frame never mixes old and new digits.

Parameters:
- REFRESH_DIV, 50000, clock cycles each digit is lit; legal range 2..2^20.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- bcd_in  input  12  BCD word: [11:8] hundreds, [7:4] tens, [3:0] units.
- load  input  1  single-cycle strobe; bcd_in is valid this cycle.
- blank_en  input  1  1 = enable leading-zero blanking.
- seg_n  output  7  active-low segments, bit order {g,f,e,d,c,b,a}; registered.
- an_n  output  3  active-low anodes: bit0 units, bit1 tens, bit2 hundreds; registered.
- frame_done  output  1  one-cycle pulse when a display-register update slot occurs; registered.

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low.
- State cleared while rst_n=0 at a clk edge:
  - prescaler = 0, idx = 0, shadow = 0, disp = 0, pending = 0.
  - seg_n = 7'h7F, an_n = 3'b111, frame_done = 0.
  - A reset asserted mid-frame discards any pending load.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps.
  - tick = 1 in the cycle where prescaler == REFRESH_DIV-1.
- Digit index:
  - On tick, idx advances 0→1→2→0; otherwise it holds. idx=3 is unreachable.
  - Frame length is 3*REFRESH_DIV cycles.
- Load capture:
  - load=1 → shadow <= bcd_in and pending <= 1, at that edge.
  - A later load before transfer overwrites shadow; last load wins.
- Transfer:
  - Occurs on tick with idx==2 (the wrap to 0). If pending=1: disp <= shadow and pending <= 0.
  - frame_done <= 1 for one cycle on every wrap tick, whether or not pending was set.
- Load coinciding with the transfer edge:
  - The transfer uses the old shadow.
  - shadow <= bcd_in and pending stays 1, so the new value appears one frame later.
- Output registers:
  - Every non-reset cycle, seg_n and an_n are updated from the current idx and disp, one cycle behind idx.
  - an_n = ~(3'b001 << idx).
- Decode of the selected nibble d, shown active-high before inversion; seg_n = ~pattern:
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66
  - 5 = 6D, 6 = 7D, 7 = 07, 8 = 7F, 9 = 6F
  - A..F (invalid BCD) = 40 (dash).
- Blanking (blank_en=1):
  - Hundreds is blanked if its nibble is 0.
  - Tens is blanked if both hundreds and tens are 0.
  - Units is never blanked.
  - A blanked digit gives seg_n = 7'h7F with its anode still driven.
  - An invalid nibble counts as nonzero for blanking.
- With blank_en=0, no digit is blanked. blank_en is sampled live, not shadowed.
- Load latency: a load at edge t is displayed from the first wrap tick after t, plus 1 cycle for the output register. Worst case is 3*REFRESH_DIV+1 cycles.

Test Plan (REFRESH_DIV=4):
- Reset: rst_n=0 for 3 cycles → seg_n=7F, an_n=111, frame_done=0.
  - After release, next edge gives an_n=110, seg_n=40 (units "0", disp=0).
  - an_n then steps 101, 011 every 4 cycles.
- Load 12'h255, blank_en=0: after the next wrap, units seg_n=12 ("5") with an_n=110, tens 24 ("2"), hundreds 24 ("2").
  - frame_done pulses once per 12 cycles.
- Blanking with disp=12'h009:
  - blank_en=1 → hundreds=7F, tens=7F, units=10 ("9").
  - blank_en=0 → hundreds=40, tens=40, units=10.
  - disp=12'h105 with blank_en=1 → tens shows 40 (not blanked).
- Invalid nibble: load 12'h1A3 → tens seg_n=3F (dash), hundreds=79 ("1"), units=30 ("3").
- Load coinciding with transfer:
  - load 12'h111, then load 12'h222 exactly on the wrap tick → frame N+1 shows 111, frame N+2 shows 222.
  - Two loads within one frame (333 then 444) → only 444 is displayed.
- Reset mid-operation: load 12'h987, assert rst_n=0 before the wrap → outputs 7F/111, and after release the display shows 000, not 987.

Source files
------------

// File: rtl/bcd_seg_scanner.sv
// bcd_seg_scanner: drives a 3-digit common-anode seven-segment display from a
// 12-bit BCD word. Digits are time-multiplexed at REFRESH_DIV cycles each.
// A shadow register collects loads, and a new value reaches the display
// register only at the frame wrap, so no frame ever mixes old and new digits.
// Leading-zero blanking is optional and follows blank_en live.
module bcd_seg_scanner #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [11:0] bcd_in,
    input  logic        load,
    input  logic        blank_en,
    output logic [6:0]  seg_n,
    output logic [2:0]  an_n,
    output logic        frame_done
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [PW-1:0] prescaler_r;
    logic [1:0]    idx_r;
    logic [11:0]   shadow_r;
    logic [11:0]   disp_r;
    logic          pending_r;

    logic          tick_s;
    logic          wrap_s;
    logic [3:0]    nib_s;
    logic          blank_s;
    logic [6:0]    seg_next_s;

    // Active-high segment pattern {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] p;
        case (d)
            4'd0:    p = 7'h3F;
            4'd1:    p = 7'h06;
            4'd2:    p = 7'h5B;
            4'd3:    p = 7'h4F;
            4'd4:    p = 7'h66;
            4'd5:    p = 7'h6D;
            4'd6:    p = 7'h7D;
            4'd7:    p = 7'h07;
            4'd8:    p = 7'h7F;
            4'd9:    p = 7'h6F;
            default: p = 7'h40;
        endcase
        return p;
    endfunction

    assign tick_s = (prescaler_r == PRESC_LAST);
    assign wrap_s = tick_s && (idx_r == 2'd2);

    // Select the nibble of the lit digit and decide whether it is blanked.
    always_comb begin
        nib_s   = disp_r[3:0];
        blank_s = 1'b0;
        case (idx_r)
            2'd1: begin
                nib_s   = disp_r[7:4];
                blank_s = (disp_r[11:8] == 4'd0) && (disp_r[7:4] == 4'd0);
            end
            2'd2: begin
                nib_s   = disp_r[11:8];
                blank_s = (disp_r[11:8] == 4'd0);
            end
            default: begin
                nib_s   = disp_r[3:0];
                blank_s = 1'b0;
            end
        endcase
        if (blank_en && blank_s) begin
            seg_next_s = 7'h7F;
        end else begin
            seg_next_s = ~seg_decode(nib_s);
        end
    end

    // Prescaler, digit scan, shadow/display transfer and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prescaler_r <= '0;
            idx_r       <= 2'd0;
            shadow_r    <= 12'h000;
            disp_r      <= 12'h000;
            pending_r   <= 1'b0;
            seg_n       <= 7'h7F;
            an_n        <= 3'b111;
            frame_done  <= 1'b0;
        end else begin
            if (tick_s) begin
                prescaler_r <= '0;
                idx_r       <= (idx_r == 2'd2) ? 2'd0 : (idx_r + 2'd1);
            end else begin
                prescaler_r <= prescaler_r + PW'(1);
            end

            // Transfer reads the pre-edge shadow, so a coincident load lands next frame.
            if (wrap_s && pending_r) begin
                disp_r <= shadow_r;
            end

            if (load) begin
                shadow_r  <= bcd_in;
                pending_r <= 1'b1;
            end else if (wrap_s) begin
                pending_r <= 1'b0;
            end

            frame_done <= wrap_s;
            seg_n      <= seg_next_s;
            an_n       <= ~(3'b001 << idx_r);
        end
    end

endmodule
